mem_ctrl: RTL and testbench
===========================

// Module: mem_ctrl
// PURPOSE
//  Single-port memory controller between the pipeline and a byte-wide synchronous RAM.
//  It serves two clients:
//   - the IF stage: word instruction fetch, read only;
//   - the MEM stage: byte, half or word load/store.
//  Each access is serialised into 1-4 byte beats, with little-endian assembly and disassembly.
//  It drives each client's busy/done handshake, which the stage uses to raise its stall request.
// PARAMETERS
//  ADDR_W   32  address width, client and RAM side
//  IF_PRIO  0   0: MEM wins simultaneous requests; 1: IF wins
// PORTS
//  clk        in   1       clock, all state on rising edge
//  rst        in   1       reset, asynchronous, active-low
//  if_re      in   1       IF read request (level; held until if_done)
//  if_addr    in   ADDR_W  IF fetch address (word read)
//  if_busy    out  1       IF request pending or in service
//  if_done    out  1       1-cycle pulse: if_data valid
//  if_data    out  32      fetched instruction, held until next IF transaction completes
//  mem_re     in   1       MEM load request (level)
//  mem_we     in   1       MEM store request (level); mem_we wins over mem_re
//  mem_size   in   2       0 byte, 1 half, 2 word; 3 treated as word
//  mem_addr   in   ADDR_W  MEM access address
//  mem_wdata  in   32      store data, low bytes used
//  mem_busy   out  1       MEM request pending or in service
//  mem_done   out  1       1-cycle pulse: load data valid / store complete
//  mem_rdata  out  32      load data, zero-extended, held until next MEM load completes
//  ram_addr   out  ADDR_W  RAM byte address
//  ram_rw     out  1       1 write, 0 read
//  ram_din    out  8       byte to RAM
//  ram_dout   in   8       byte from RAM, valid the cycle after its address
// BEHAVIOUR
//  Reset (async, rst=0): all outputs 0, state IDLE, counters 0.
//  - Any beat in flight is abandoned; a partial store is not completed.
//  States: IDLE -> ADDR -> (READ: TAIL) -> DONE -> IDLE.
//  IDLE:
//  - Samples requests each edge; with none pending it stays in IDLE.
//  - With a request it latches the winner: client, address, size (n = 1/2/4 beats) and write data.
//  - Goes to ADDR with the beat counter k = 0.
//  - Tie: MEM wins if IF_PRIO=0, IF wins if IF_PRIO=1.
//  ADDR, one cycle per beat:
//  - ram_addr = addr + k, modulo 2^ADDR_W; wraps past the top address.
//  - Store: ram_rw=1, ram_din = wdata[8k+7:8k].
//  - After beat n-1: a store goes to DONE; a load goes to TAIL.
//  Load capture:
//  - ram_dout is captured into byte lane k-1 at the edge that ends the cycle after beat k-1.
//  - TAIL is one cycle that captures the last byte.
//  - Unused upper lanes are 0.
//  DONE (one cycle):
//  - The owning client's done=1 and busy=0; its data output is updated from that cycle on.
//  - ram_rw=0; the next state is IDLE.
//  - A request still asserted in that IDLE cycle is accepted as a new transaction.
//  Latency, with acceptance at edge E0:
//  - load: done in the (n+2)th cycle after E0 (word: 6th);
//  - store: done in the (n+1)th cycle after E0.
//  busy:
//  - The owner has busy=1 from the cycle after acceptance until DONE, exclusive.
//  - A requester that is not the owner has busy=1 while the other client is being served.
//  - In IDLE, busy = 0 for both clients.
//  Request handling:
//  - Request inputs are ignored outside IDLE; a client changing address mid-transaction has no effect.
//  - ram_rw is 1 only in ADDR for a store; otherwise 0, and ram_din = 0.
// TESTING
//  - IF word read 0x100; RAM[0x100..103] = 93,00,10,00 -> if_done in 6th cycle after accept, if_data = 0x00100093.
//  - MEM byte store 0x2003, wdata = 0xAABBCCDD -> one write beat 0x2003 <- DD; mem_done in 2nd cycle.
//    Readback half from 0x2002 -> 0x0000DD00.
//  - IF and MEM assert together (IF_PRIO=0) -> MEM served first, if_busy = 1 throughout.
//    IF is accepted in the IDLE cycle after mem_done.
//  - Word load at 0xFFFFFFFE -> beat addresses FFFFFFFE, FFFFFFFF, 0, 1; bytes assembled in that order.
//  - rst low during beat 2 of a word store -> ram_rw = 0 at once, outputs 0, bytes 2-3 unwritten.
//    After release an IF fetch proceeds normally.
//  - mem_we and mem_re both high, size = 1 -> store of 2 bytes only, mem_rdata unchanged.

Source files
------------

// File: rtl/mem_ctrl_if.sv
// Client and RAM-side signal bundle for mem_ctrl: IF fetch port, MEM load/store port,
// and the byte-wide synchronous RAM port.
interface mem_ctrl_if #(
   parameter int unsigned ADDR_W = 32
);
   logic              if_re;
   logic [ADDR_W-1:0] if_addr;
   logic              if_busy;
   logic              if_done;
   logic [31:0]       if_data;

   logic              mem_re;
   logic              mem_we;
   logic [1:0]        mem_size;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_wdata;
   logic              mem_busy;
   logic              mem_done;
   logic [31:0]       mem_rdata;

   logic [ADDR_W-1:0] ram_addr;
   logic              ram_rw;
   logic [7:0]        ram_din;
   logic [7:0]        ram_dout;

   modport slave (
      input  if_re, if_addr, mem_re, mem_we, mem_size, mem_addr, mem_wdata, ram_dout,
      output if_busy, if_done, if_data, mem_busy, mem_done, mem_rdata,
             ram_addr, ram_rw, ram_din
   );

   modport master (
      output if_re, if_addr, mem_re, mem_we, mem_size, mem_addr, mem_wdata, ram_dout,
      input  if_busy, if_done, if_data, mem_busy, mem_done, mem_rdata,
             ram_addr, ram_rw, ram_din
   );
endinterface

// File: rtl/mem_ctrl.sv
// Single-port controller serialising IF word fetches and MEM byte/half/word loads and
// stores into little-endian byte beats on a byte-wide synchronous RAM.
module mem_ctrl #(
   parameter int unsigned ADDR_W  = 32,
   parameter bit          IF_PRIO = 1'b0
) (
   input  logic       clk,
   input  logic       rst,
   mem_ctrl_if.slave  bus
);

   typedef enum logic [1:0] {IDLE, ADDR, TAIL, DONE} state_t;

   state_t            state;
   logic              own_if;
   logic              wr;
   logic [ADDR_W-1:0] addr;
   logic [1:0]        last;
   logic [1:0]        k;
   logic [31:0]       wdata;
   logic [31:0]       rbuf;

   logic              mem_req;
   logic              pick_if;
   logic              acc_wr;
   logic [ADDR_W-1:0] acc_addr;
   logic [1:0]        k_nx;
   logic [1:0]        k_prev;
   logic [31:0]       tail_word;

   function automatic logic [1:0] last_beat(input logic [1:0] size);
      case (size)
         2'd0:    return 2'd0;
         2'd1:    return 2'd1;
         default: return 2'd3;
      endcase
   endfunction

   always_comb begin
      mem_req  = bus.mem_re | bus.mem_we;
      pick_if  = IF_PRIO ? bus.if_re : (bus.if_re & ~mem_req);
      acc_wr   = ~pick_if & bus.mem_we;
      acc_addr = pick_if ? bus.if_addr : bus.mem_addr;
      k_nx     = k + 2'd1;
      k_prev   = k - 2'd1;
      // The last byte arrives during TAIL; merge it with the lanes already captured.
      tail_word = rbuf;
      tail_word[{last, 3'b000} +: 8] = bus.ram_dout;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state        <= IDLE;
         own_if       <= 1'b0;
         wr           <= 1'b0;
         addr         <= '0;
         last         <= '0;
         k            <= '0;
         wdata        <= '0;
         rbuf         <= '0;
         bus.if_busy  <= 1'b0;
         bus.if_done  <= 1'b0;
         bus.if_data  <= '0;
         bus.mem_busy <= 1'b0;
         bus.mem_done <= 1'b0;
         bus.mem_rdata <= '0;
         bus.ram_addr <= '0;
         bus.ram_rw   <= 1'b0;
         bus.ram_din  <= '0;
      end else begin
         bus.if_done  <= 1'b0;
         bus.mem_done <= 1'b0;
         case (state)
            IDLE: begin
               bus.if_busy  <= 1'b0;
               bus.mem_busy <= 1'b0;
               if (pick_if || mem_req) begin
                  own_if       <= pick_if;
                  wr           <= acc_wr;
                  addr         <= acc_addr;
                  last         <= pick_if ? 2'd3 : last_beat(bus.mem_size);
                  wdata        <= pick_if ? '0 : bus.mem_wdata;
                  k            <= '0;
                  rbuf         <= '0;
                  bus.ram_addr <= acc_addr;
                  bus.ram_rw   <= acc_wr;
                  bus.ram_din  <= acc_wr ? bus.mem_wdata[7:0] : '0;
                  bus.if_busy  <= bus.if_re;
                  bus.mem_busy <= mem_req;
                  state        <= ADDR;
               end
            end
            ADDR: begin
               // Read data lags its address by one cycle, so beat k delivers lane k-1.
               if (!wr && k != 2'd0) rbuf[{k_prev, 3'b000} +: 8] <= bus.ram_dout;
               if (own_if) bus.mem_busy <= mem_req;
               else        bus.if_busy  <= bus.if_re;
               if (k == last) begin
                  bus.ram_addr <= '0;
                  bus.ram_rw   <= 1'b0;
                  bus.ram_din  <= '0;
                  if (wr) begin
                     bus.mem_done <= 1'b1;
                     bus.mem_busy <= 1'b0;
                     state        <= DONE;
                  end else begin
                     state <= TAIL;
                  end
               end else begin
                  k            <= k_nx;
                  bus.ram_addr <= addr + {{(ADDR_W-2){1'b0}}, k_nx};
                  bus.ram_rw   <= wr;
                  bus.ram_din  <= wr ? wdata[{k_nx, 3'b000} +: 8] : '0;
               end
            end
            TAIL: begin
               state <= DONE;
               if (own_if) begin
                  bus.mem_busy <= mem_req;
                  bus.if_data  <= tail_word;
                  bus.if_done  <= 1'b1;
                  bus.if_busy  <= 1'b0;
               end else begin
                  bus.if_busy   <= bus.if_re;
                  bus.mem_rdata <= tail_word;
                  bus.mem_done  <= 1'b1;
                  bus.mem_busy  <= 1'b0;
               end
            end
            DONE: begin
               bus.if_busy  <= 1'b0;
               bus.mem_busy <= 1'b0;
               state        <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed self-checking bench for mem_ctrl with a byte-wide synchronous RAM model
// and a backdoor preload port.
module tb_mem_ctrl;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   mem_ctrl_if #(.ADDR_W(32)) bus();

   mem_ctrl #(.ADDR_W(32), .IF_PRIO(1'b0)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   logic [7:0]  ram [0:65535];
   logic        bd_clr = 1'b0;
   logic        bd_we  = 1'b0;
   logic [15:0] bd_addr = '0;
   logic [7:0]  bd_data = '0;

   always @(posedge clk) begin
      if (bd_clr) begin
         for (int i = 0; i < 65536; i++) ram[i] <= 8'h00;
      end else if (bd_we) begin
         ram[bd_addr] <= bd_data;
      end else if (bus.ram_rw) begin
         ram[bus.ram_addr[15:0]] <= bus.ram_din;
      end
      bus.ram_dout <= ram[bus.ram_addr[15:0]];
   end

   int unsigned n_cmp = 0;
   int unsigned n_bad = 0;

   logic [31:0] tr_addr [1:16];
   logic        tr_rw   [1:16];
   logic [7:0]  tr_din  [1:16];
   logic        tr_ib   [1:16];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic poke(input logic [15:0] a, input logic [7:0] d);
      @(negedge clk);
      bd_we = 1'b1; bd_addr = a; bd_data = d;
      @(negedge clk);
      bd_we = 1'b0;
   endtask

   // Called at a negedge in IDLE; returns the cycle (1-based after acceptance) of done, or -1.
   task automatic run(input bit use_if, input bit re, input bit we, input logic [1:0] sz,
                      input logic [31:0] a, input logic [31:0] wd, output int cyc);
      if (use_if) begin
         bus.if_re = 1'b1; bus.if_addr = a;
      end else begin
         bus.mem_re = re; bus.mem_we = we; bus.mem_size = sz;
         bus.mem_addr = a; bus.mem_wdata = wd;
      end
      cyc = -1;
      for (int c = 1; c <= 16; c++) begin
         @(negedge clk);
         tr_addr[c] = bus.ram_addr;
         tr_rw[c]   = bus.ram_rw;
         tr_din[c]  = bus.ram_din;
         tr_ib[c]   = bus.if_busy;
         if (use_if ? bus.if_done : bus.mem_done) begin
            cyc = c;
            break;
         end
      end
      bus.if_re = 1'b0; bus.mem_re = 1'b0; bus.mem_we = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      int cyc, md, id, bad_busy;
      bus.if_re = 1'b0; bus.if_addr = '0;
      bus.mem_re = 1'b0; bus.mem_we = 1'b0; bus.mem_size = '0;
      bus.mem_addr = '0; bus.mem_wdata = '0;

      @(negedge clk); bd_clr = 1'b1;
      @(negedge clk); bd_clr = 1'b0;
      poke(16'h0100, 8'h93); poke(16'h0101, 8'h00); poke(16'h0102, 8'h10); poke(16'h0103, 8'h00);
      poke(16'h0300, 8'h11); poke(16'h0301, 8'h22); poke(16'h0302, 8'h33); poke(16'h0303, 8'h44);
      poke(16'hFFFE, 8'hA1); poke(16'hFFFF, 8'hB2); poke(16'h0000, 8'hC3); poke(16'h0001, 8'hD4);

      check("rst ram_rw",   bus.ram_rw,   0);
      check("rst ram_addr", bus.ram_addr, 0);
      check("rst if_busy",  bus.if_busy,  0);
      check("rst mem_busy", bus.mem_busy, 0);
      check("rst if_data",  bus.if_data,  0);

      @(negedge clk); rst = 1'b1;
      @(negedge clk);

      // IF word fetch
      run(1'b1, 1'b0, 1'b0, 2'd2, 32'h0000_0100, 32'h0, cyc);
      check("if fetch latency", cyc, 6);
      check("if fetch data", bus.if_data, 32'h0010_0093);
      check("if beat0 addr", tr_addr[1], 32'h100);
      check("if beat3 addr", tr_addr[4], 32'h103);
      check("if busy cycle1", tr_ib[1], 1);
      check("if busy at done", tr_ib[6], 0);
      check("if done pulse", bus.if_done, 0);

      // MEM byte store, then half readback
      run(1'b0, 1'b0, 1'b1, 2'd0, 32'h0000_2003, 32'hAABB_CCDD, cyc);
      check("sb latency", cyc, 2);
      check("sb addr", tr_addr[1], 32'h2003);
      check("sb rw", tr_rw[1], 1);
      check("sb din", tr_din[1], 32'hDD);
      check("sb rw at done", tr_rw[2], 0);
      check("sb ram 2003", ram[16'h2003], 32'hDD);
      check("sb ram 2004", ram[16'h2004], 32'h00);
      check("sb rdata kept", bus.mem_rdata, 0);
      run(1'b0, 1'b1, 1'b0, 2'd1, 32'h0000_2002, 32'h0, cyc);
      check("lh latency", cyc, 4);
      check("lh data", bus.mem_rdata, 32'h0000_DD00);

      // Simultaneous requests, MEM wins
      bus.if_re = 1'b1; bus.if_addr = 32'h300;
      bus.mem_re = 1'b1; bus.mem_size = 2'd0; bus.mem_addr = 32'h2003;
      md = -1; id = -1; bad_busy = 0;
      for (int c = 1; c <= 24; c++) begin
         @(negedge clk);
         if (md < 0) begin
            if (!bus.if_busy) bad_busy++;
            if (bus.mem_done) begin
               md = c;
               bus.mem_re = 1'b0;
            end
         end else if (c == md + 1) begin
            check("tie if_busy idle", bus.if_busy, 0);
         end
         if (bus.if_done) begin
            id = c;
            bus.if_re = 1'b0;
            break;
         end
      end
      @(negedge clk);
      check("tie mem latency", md, 3);
      check("tie if_busy held", bad_busy, 0);
      check("tie mem data", bus.mem_rdata, 32'h0000_00DD);
      check("tie if latency", id, 10);
      check("tie if data", bus.if_data, 32'h4433_2211);

      // Word load wrapping past the top address
      run(1'b0, 1'b1, 1'b0, 2'd2, 32'hFFFF_FFFE, 32'h0, cyc);
      check("wrap latency", cyc, 6);
      check("wrap beat0", tr_addr[1], 32'hFFFF_FFFE);
      check("wrap beat1", tr_addr[2], 32'hFFFF_FFFF);
      check("wrap beat2", tr_addr[3], 32'h0000_0000);
      check("wrap beat3", tr_addr[4], 32'h0000_0001);
      check("wrap data", bus.mem_rdata, 32'hD4C3_B2A1);

      // Reset during beat 2 of a word store
      bus.mem_we = 1'b1; bus.mem_size = 2'd2; bus.mem_addr = 32'h4000; bus.mem_wdata = 32'h4433_2211;
      repeat (3) @(negedge clk);
      check("sw beat2 addr", bus.ram_addr, 32'h4002);
      check("sw beat2 din", bus.ram_din, 32'h33);
      rst = 1'b0;
      #1;
      check("async rst ram_rw", bus.ram_rw, 0);
      check("async rst ram_addr", bus.ram_addr, 0);
      check("async rst mem_busy", bus.mem_busy, 0);
      check("async rst rdata", bus.mem_rdata, 0);
      bus.mem_we = 1'b0;
      @(negedge clk); rst = 1'b1;
      @(negedge clk);
      check("sw ram 4000", ram[16'h4000], 32'h11);
      check("sw ram 4001", ram[16'h4001], 32'h22);
      check("sw ram 4002", ram[16'h4002], 32'h00);
      check("sw ram 4003", ram[16'h4003], 32'h00);
      run(1'b1, 1'b0, 1'b0, 2'd2, 32'h0000_0100, 32'h0, cyc);
      check("post rst latency", cyc, 6);
      check("post rst data", bus.if_data, 32'h0010_0093);

      // Store wins over load when both asserted
      run(1'b0, 1'b1, 1'b0, 2'd0, 32'h0000_2003, 32'h0, cyc);
      check("lb latency", cyc, 3);
      check("lb data", bus.mem_rdata, 32'h0000_00DD);
      run(1'b0, 1'b1, 1'b1, 2'd1, 32'h0000_5000, 32'h0000_BEEF, cyc);
      check("we+re latency", cyc, 3);
      check("we+re rw beat1", tr_rw[2], 1);
      check("we+re rdata kept", bus.mem_rdata, 32'h0000_00DD);
      check("we+re ram 5000", ram[16'h5000], 32'hEF);
      check("we+re ram 5001", ram[16'h5001], 32'hBE);
      check("we+re ram 5002", ram[16'h5002], 32'h00);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
